fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one sync FIFO write port among N producers.

---
 rtl/fifo_wr_arbiter_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port round-robin arbiter.
// Optional burst lock is enabled with `define WRARB_BURST_EN.
package fifo_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

   localparam int N_DEF         = 4;
   localparam int DW_DEF        = 8;
   localparam int BURST_LEN_DEF = 4;

   // Width of a requester index; never narrower than one bit.
   function automatic int ptr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter: requests, grants and FIFO write port.
// master = arbiter side, slave = producers plus FIFO.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF
) ();

   localparam int PW = ptr_w(N);

   logic [N-1:0]    req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    gnt;
   logic            w_en;
   logic [DW-1:0]   data_in;
   logic            full;
   logic [PW-1:0]   owner;

   modport master (
      input  req, req_data, full,
      output gnt, w_en, data_in, owner
   );

   modport slave (
      output req, req_data, full,
      input  gnt, w_en, data_in, owner
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping mod N.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int PW = ptr_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  sel,
   output logic [PW-1:0] idx,
   output logic          any
);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      sel = '0;
      idx = '0;
      any = 1'b0;
      // Scan from farthest to nearest so the nearest hit is the one that sticks.
      for (int k = N - 1; k >= 0; k--) begin
         int j;
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            sel = N'(1) << j;
            idx = PW'(j);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port among N producers.
// Define WRARB_BURST_EN to let one owner keep the port for up to BURST_LEN beats.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int DW        = DW_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   fifo_wr_arbiter_if.master bus
);

   localparam int            PW   = ptr_w(N);
   localparam logic [PW-1:0] LAST = PW'(N - 1);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [N-1:0]  pick_sel;
   logic [PW-1:0] pick_idx;
   logic          pick_any;
   logic [N-1:0]  gnt_c;
   logic [PW-1:0] gnt_idx;
   logic          gnt_any;

   function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
      return (i == LAST) ? '0 : i + PW'(1);
   endfunction

   rr_pick #(.N(N), .PW(PW)) u_pick (
      .req (bus.req),
      .ptr (ptr_q),
      .sel (pick_sel),
      .idx (pick_idx),
      .any (pick_any)
   );

`ifdef WRARB_BURST_EN
   localparam int CW = $clog2(BURST_LEN + 1);

   arb_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gnt_c   = '0;
      gnt_idx = owner_q;
      gnt_any = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (!bus.full && pick_any) begin
               gnt_c   = pick_sel;
               gnt_idx = pick_idx;
               gnt_any = 1'b1;
               owner_d = pick_idx;
               ptr_d   = next_idx(pick_idx);
               // A one-beat burst never locks, matching plain rotation.
               if (BURST_LEN > 1) begin
                  state_d = ARB_LOCK;
                  cnt_d   = CW'(1);
               end
            end
         end
         ARB_LOCK: begin
            if (!bus.full) begin
               if (bus.req[owner_q]) begin
                  gnt_c   = N'(1) << owner_q;
                  gnt_any = 1'b1;
                  cnt_d   = cnt_q + CW'(1);
                  if (cnt_q + CW'(1) == CW'(BURST_LEN)) begin
                     state_d = ARB_IDLE;
                     ptr_d   = next_idx(owner_q);
                     cnt_d   = '0;
                  end
               end else begin
                  state_d = ARB_IDLE;
                  ptr_d   = next_idx(owner_q);
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end
`else
   always_comb begin
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gnt_c   = '0;
      gnt_idx = pick_idx;
      gnt_any = 1'b0;
      if (!bus.full && pick_any) begin
         gnt_c   = pick_sel;
         gnt_any = 1'b1;
         owner_d = pick_idx;
         ptr_d   = next_idx(pick_idx);
      end
   end
`endif

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         owner_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
      end
   end

   // Outputs are forced quiet while reset is low so no beat is written on that edge.
   assign bus.gnt     = rst_n ? gnt_c : '0;
   assign bus.w_en    = rst_n & gnt_any;
   assign bus.data_in = bus.w_en ? bus.req_data[gnt_idx*DW +: DW] : '0;
   assign bus.owner   = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed table, full/reset sequences, random traffic
// against a queue-based FIFO and a rule-level arbiter model. Honors WRARB_BURST_EN.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int BL    = 4;
   localparam int DEPTH = 8;

   typedef struct {
      logic [N-1:0] req;
      bit           full;
      bit           pop;
      logic [N-1:0] gnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.N(N), .DW(DW)) bus ();

   fifo_wr_arbiter #(.N(N), .DW(DW), .BURST_LEN(BL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int           n_checks = 0;
   int           n_pass   = 0;
   int           m_ptr, m_owner, m_beats;
   bit           m_locked;
   bit           force_full = 1'b0;
   bit           rand_data  = 1'b0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] dat[N];
   vec_t          vt[$];
   logic [N-1:0]  gs;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_ptr = 0; m_owner = 0; m_beats = 0; m_locked = 1'b0;
   endtask

   // Who should be granted this cycle, from the arbitration rules; -1 for nobody.
   function automatic int model_pick(input logic [N-1:0] r, input bit f);
      if (f) return -1;
`ifdef WRARB_BURST_EN
      if (m_locked) return r[m_owner] ? m_owner : -1;
`endif
      for (int k = 0; k < N; k++)
         if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic model_commit(input int g, input logic [N-1:0] r, input bit f);
      if (g >= 0) begin
         m_owner = g;
         m_ptr   = (g + 1) % N;
`ifdef WRARB_BURST_EN
         if (!m_locked) begin
            m_beats  = 1;
            m_locked = (BL > 1);
         end else begin
            m_beats++;
         end
         if (m_beats >= BL) m_locked = 1'b0;
`endif
      end else begin
`ifdef WRARB_BURST_EN
         if (m_locked && !f && !r[m_owner]) m_locked = 1'b0;
`endif
      end
   endtask

   // One clock: drive at negedge, check combinational outputs, advance FIFO and model at posedge.
   task automatic step(input logic [N-1:0] r, input bit pop, output logic [N-1:0] g_seen);
      int            g;
      bit            f;
      logic          wen_s;
      logic [DW-1:0] din_s, a, e;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         dat[i] = rand_data ? DW'($urandom) : DW'(8'hA0 + i);
         bus.req_data[i*DW +: DW] = dat[i];
      end
      bus.req  = r;
      f        = force_full || (fifo_q.size() >= DEPTH);
      bus.full = f;
      #1;
      g = model_pick(r, f);
      check("gnt", 32'(bus.gnt), (g >= 0) ? 32'(1) << g : 32'd0);
      check("w_en", 32'(bus.w_en), 32'(g >= 0));
      check("data_in", 32'(bus.data_in), (g >= 0) ? 32'(dat[g]) : 32'd0);
      check("owner", 32'(bus.owner), 32'(m_owner));
      check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      check("w_en_vs_gnt", 32'(bus.w_en), 32'(|bus.gnt));
      if (f) check("gnt_when_full", 32'(bus.gnt), 32'd0);
      g_seen = bus.gnt;
      wen_s  = bus.w_en;
      din_s  = bus.data_in;
      @(posedge clk);
      if (pop && fifo_q.size() > 0) begin
         a = fifo_q.pop_front();
         e = exp_q.pop_front();
         check("fifo_order", 32'(a), 32'(e));
      end
      if (wen_s) fifo_q.push_back(din_s);
      if (g >= 0) exp_q.push_back(dat[g]);
      model_commit(g, r, f);
   endtask

   task automatic add(input logic [N-1:0] r, input bit f, input bit p, input logic [N-1:0] g);
      vec_t v;
      v.req = r; v.full = f; v.pop = p; v.gnt = g;
      vt.push_back(v);
   endtask

   initial begin
      model_reset();
`ifdef WRARB_BURST_EN
      for (int i = 0; i < 4; i++) add(4'b0011, 1'b0, 1'b1, 4'b0001);
      for (int i = 0; i < 4; i++) add(4'b0011, 1'b0, 1'b1, 4'b0010);
      add(4'b0011, 1'b0, 1'b1, 4'b0001);
      add(4'b0011, 1'b0, 1'b1, 4'b0001);
      add(4'b0010, 1'b0, 1'b1, 4'b0000);
      add(4'b0010, 1'b0, 1'b1, 4'b0010);
`else
      add(4'b1111, 1'b0, 1'b1, 4'b0001);
      add(4'b1111, 1'b0, 1'b1, 4'b0010);
      add(4'b1111, 1'b0, 1'b1, 4'b0100);
      add(4'b1111, 1'b0, 1'b1, 4'b1000);
      add(4'b1111, 1'b0, 1'b1, 4'b0001);
      add(4'b0100, 1'b0, 1'b1, 4'b0100);
      add(4'b0101, 1'b0, 1'b1, 4'b0001);
      add(4'b0101, 1'b0, 1'b1, 4'b0100);
      add(4'b0000, 1'b0, 1'b1, 4'b0000);
      add(4'b0010, 1'b1, 1'b1, 4'b0000);
      add(4'b0010, 1'b0, 1'b1, 4'b0010);
`endif

      // Reset with every producer requesting: nothing may be granted.
      rst_n        = 1'b0;
      bus.req      = 4'b1111;
      bus.req_data = '0;
      bus.full     = 1'b0;
      #12;
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_w_en", 32'(bus.w_en), 32'd0);
      check("rst_data_in", 32'(bus.data_in), 32'd0);
      check("rst_owner", 32'(bus.owner), 32'd0);
      @(negedge clk);
      bus.req = '0;
      rst_n   = 1'b1;

      // Directed table from the reset state.
      foreach (vt[i]) begin
         force_full = vt[i].full;
         step(vt[i].req, vt[i].pop, gs);
         check($sformatf("vec%0d", i), 32'(gs), 32'(vt[i].gnt));
      end
      force_full = 1'b0;

      // FIFO full: fill to depth, grant withheld until one entry is popped.
      for (int k = 0; k < DEPTH + 2 && fifo_q.size() > 0; k++) step('0, 1'b1, gs);
      for (int k = 0; k < DEPTH; k++) step(4'b1111, 1'b0, gs);
      step(4'b0010, 1'b1, gs);
      check("full_hold", 32'(gs), 32'd0);
      step(4'b0010, 1'b0, gs);
      check("after_pop", 32'(gs), 32'b0010);

      // Random traffic against the model.
      rand_data = 1'b1;
      for (int k = 0; k < 400; k++) begin
         force_full = ($urandom_range(0, 9) == 0);
         step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), gs);
      end
      force_full = 1'b0;
      rand_data  = 1'b0;

      // Async reset in the middle of ownership: outputs drop at once, restart from requester 0.
      step(4'b1111, 1'b1, gs);
      step(4'b1111, 1'b1, gs);
      @(negedge clk);
      bus.req = 4'b1111;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
      check("mid_rst_w_en", 32'(bus.w_en), 32'd0);
      check("mid_rst_data_in", 32'(bus.data_in), 32'd0);
      check("mid_rst_owner", 32'(bus.owner), 32'd0);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      bus.req = '0;
      rst_n   = 1'b1;
      step(4'b1111, 1'b1, gs);
      check("restart_gnt", 32'(gs), 32'b0001);
      step(4'b1010, 1'b1, gs);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
